// File: rtl/ysyx_24110015_pkg.sv
// Shared types and defaults for the IFU/LSU memory arbiter.
// Holds the FSM state enum, the owner encoding and the default bus widths.
package ysyx_24110015_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

endpackage

// File: rtl/ysyx_24110015_rr_arb2.sv
// Two-way round-robin choice: a lone requester wins, a tie goes to the side
// that was not granted last. Purely combinational; bit 0 = IFU, bit 1 = LSU.
module ysyx_24110015_rr_arb2 (
    input  logic [1:0]                 req,
    input  ysyx_24110015_pkg::owner_e last_grant,
    output logic [1:0]                grant
);
    import ysyx_24110015_pkg::*;

    // One-hot grant selection
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant == OWN_IFU) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/ysyx_24110015_mem_arbiter.sv
// Shares one memory port between the IFU (read-only) and the LSU (read/write),
// with a single outstanding transaction and round-robin arbitration on ties.
module ysyx_24110015_mem_arbiter #(
    parameter int ADDR_W = ysyx_24110015_pkg::DEF_ADDR_W,
    parameter int DATA_W = ysyx_24110015_pkg::DEF_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_rsp_valid,
    input  logic                ifu_rsp_ready,
    output logic [DATA_W-1:0]   ifu_rdata,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_rsp_valid,
    input  logic                lsu_rsp_ready,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_rsp_valid,
    output logic                mem_rsp_ready,
    input  logic [DATA_W-1:0]   mem_rdata
);
    import ysyx_24110015_pkg::*;

    localparam int MASK_W = DATA_W / 8;

    state_e              state_r;
    state_e              state_s;
    owner_e              owner_r;
    owner_e              last_grant_r;
    logic [1:0]          grant_s;
    logic                accept_s;
    logic                rsp_ready_s;
    logic [ADDR_W-1:0]   addr_r;
    logic                wen_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [MASK_W-1:0]   wmask_r;

    ysyx_24110015_rr_arb2 u_arb (
        .req        ({lsu_req_valid, ifu_req_valid}),
        .last_grant (last_grant_r),
        .grant      (grant_s)
    );

    // The request side is driven only from latched fields, so it is stable across stalls
    assign mem_req_valid = (state_r == ST_REQ);
    assign mem_addr      = addr_r;
    assign mem_wen       = wen_r;
    assign mem_wdata     = wdata_r;
    assign mem_wmask     = wmask_r;
    assign mem_rsp_ready = rsp_ready_s;

    // Next-state, handshake steering and response routing
    always_comb begin
        state_s       = state_r;
        accept_s      = 1'b0;
        rsp_ready_s   = 1'b0;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        lsu_rsp_valid = 1'b0;
        ifu_rdata     = {DATA_W{1'b0}};
        lsu_rdata     = {DATA_W{1'b0}};
        case (state_r)
            ST_IDLE: begin
                // rst gates ready so nothing looks acceptable while held in reset
                ifu_req_ready = grant_s[0] & rst;
                lsu_req_ready = grant_s[1] & rst;
                if (grant_s != 2'b00) begin
                    accept_s = 1'b1;
                    state_s  = ST_REQ;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    state_s = ST_RSP;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_RSP: begin
                if (owner_r == OWN_IFU) begin
                    ifu_rsp_valid = mem_rsp_valid;
                    ifu_rdata     = mem_rdata;
                    rsp_ready_s   = ifu_rsp_ready;
                end else begin
                    lsu_rsp_valid = mem_rsp_valid;
                    lsu_rdata     = mem_rdata;
                    rsp_ready_s   = lsu_rsp_ready;
                end
                if (mem_rsp_valid && rsp_ready_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RSP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Owner, last grant and request fields are captured on the accept cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_r      <= OWN_IFU;
            last_grant_r <= OWN_LSU;
            addr_r       <= {ADDR_W{1'b0}};
            wen_r        <= 1'b0;
            wdata_r      <= {DATA_W{1'b0}};
            wmask_r      <= {MASK_W{1'b0}};
        end else if (accept_s) begin
            if (grant_s[1]) begin
                owner_r      <= OWN_LSU;
                last_grant_r <= OWN_LSU;
                addr_r       <= lsu_addr;
                wen_r        <= lsu_wen;
                wdata_r      <= lsu_wdata;
                wmask_r      <= lsu_wmask;
            end else begin
                owner_r      <= OWN_IFU;
                last_grant_r <= OWN_IFU;
                addr_r       <= ifu_addr;
                wen_r        <= 1'b0;
                wdata_r      <= {DATA_W{1'b0}};
                wmask_r      <= {MASK_W{1'b0}};
            end
        end
    end

endmodule
